// File: rtl/seq_checker_pkg.sv
// rtl/seq_checker_pkg.sv - shared state encoding and default parameters for seq_checker
package seq_checker_pkg;

   localparam int DEF_DW      = 4;
   localparam int DEF_CW      = 16;
   localparam int DEF_MAX_ERR = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2,
      FAIL  = 2'd3
   } state_t;

endpackage

// File: rtl/sat_cntr.sv
// rtl/sat_cntr.sv - saturating up-counter with synchronous clear
module sat_cntr #(
   parameter int W = 16
) (
   input  logic         clock_i,
   input  logic         reset_n_i,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/seq_checker.sv
// rtl/seq_checker.sv - incrementing-sequence checker with sync, error capture and fail threshold
module seq_checker
   import seq_checker_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int CW      = DEF_CW,
   parameter int MAX_ERR = DEF_MAX_ERR
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          stop,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          locked,
   output logic          err_flag,
   output logic          failed,
   output logic [CW-1:0] ok_count,
   output logic [CW-1:0] err_count,
   output logic [DW-1:0] last_exp,
   output logic [DW-1:0] last_got
);

   localparam logic [CW:0] MAX_ERR_W = (CW+1)'(MAX_ERR);

   state_t        state_q, state_d;
   logic [DW-1:0] exp_q, exp_d;
   logic [DW-1:0] last_exp_q, last_exp_d;
   logic [DW-1:0] last_got_q, last_got_d;
   logic          err_flag_q, err_flag_d;
   logic          locked_q, failed_q;
   logic          beat, clear, ok_inc, err_inc, err_hits_max;
   logic [DW-1:0] data_plus1;
   logic [CW:0]   err_next;

   assign in_ready   = (state_q == SYNC) || (state_q == CHECK);
   assign beat       = in_valid && in_ready;
   assign data_plus1 = in_data + DW'(1);

   // A saturated error counter cannot step onto the threshold any more.
   assign err_next     = {1'b0, err_count} + (CW+1)'(1);
   assign err_hits_max = (MAX_ERR != 0) && (err_count != {CW{1'b1}}) && (err_next == MAX_ERR_W);

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      last_exp_d = last_exp_q;
      last_got_d = last_got_q;
      err_flag_d = err_flag_q;
      clear      = 1'b0;
      ok_inc     = 1'b0;
      err_inc    = 1'b0;

      // stop outranks start; either one swallows a beat in the same cycle
      if (stop) begin
         if (state_q != IDLE) begin
            state_d = IDLE;
         end
      end else if (start) begin
         clear      = 1'b1;
         state_d    = SYNC;
         last_exp_d = '0;
         last_got_d = '0;
         err_flag_d = 1'b0;
      end else if (beat) begin
         exp_d = data_plus1;
         if (state_q == SYNC) begin
            state_d = CHECK;
         end else if (in_data == exp_q) begin
            ok_inc = 1'b1;
         end else begin
            err_inc    = 1'b1;
            last_exp_d = exp_q;
            last_got_d = in_data;
            err_flag_d = 1'b1;
            if (err_hits_max) begin
               state_d = FAIL;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         exp_q      <= '0;
         last_exp_q <= '0;
         last_got_q <= '0;
         err_flag_q <= 1'b0;
         locked_q   <= 1'b0;
         failed_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         last_exp_q <= last_exp_d;
         last_got_q <= last_got_d;
         err_flag_q <= err_flag_d;
         locked_q   <= (state_d == CHECK);
         failed_q   <= (state_d == FAIL);
      end
   end

   sat_cntr #(.W(CW)) u_ok_cntr (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .clear_i   (clear),
      .inc_i     (ok_inc),
      .count_o   (ok_count)
   );

   sat_cntr #(.W(CW)) u_err_cntr (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .clear_i   (clear),
      .inc_i     (err_inc),
      .count_o   (err_count)
   );

   assign locked   = locked_q;
   assign failed   = failed_q;
   assign err_flag = err_flag_q;
   assign last_exp = last_exp_q;
   assign last_got = last_got_q;

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter DW, default 4, width of checked data word.
REQ-002 Parameter CW, default 16, width of beat and error counters.
REQ-003 Parameter MAX_ERR, default 8, error count that forces FAIL; 0 disables FAIL.
REQ-004 clock  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; clears counters and begins synchronisation.
REQ-007 stop  input  1  one-cycle pulse; returns to IDLE and keeps counters.
REQ-008 in_valid  input  1  producer has a word.
REQ-009 in_ready  output  1  checker accepts a word; a beat is in_valid & in_ready.
REQ-010 in_data  input  DW  word under check.
REQ-011 locked  output  1  high in CHECK state.
REQ-012 err_flag  output  1  sticky; set on first mismatch since start.
REQ-013 failed  output  1  high in FAIL state.
REQ-014 ok_count  output  CW  matching beats since start, saturating.
REQ-015 err_count  output  CW  mismatching beats since start, saturating.
REQ-016 last_exp, last_got  output  DW each  expected and received word of the most recent mismatch.

Function
REQ-017 The state machine SHALL have states IDLE, SYNC, CHECK, FAIL.
REQ-018 in_ready SHALL be combinationally 1 in SYNC and CHECK and 0 in IDLE and FAIL.
REQ-019 IDLE: start -> SYNC; all other inputs ignored.
REQ-020 SYNC: first beat loads expected = in_data + 1 (mod 2^DW) -> CHECK; no counters change.
REQ-021 CHECK, beat with in_data == expected: ok_count +1, expected = in_data + 1 (mod 2^DW).
REQ-022 CHECK, beat with in_data != expected: err_count +1, last_exp = expected, last_got = in_data, err_flag = 1, expected = in_data + 1 (resync).
REQ-023 CHECK -> FAIL on the mismatch beat that makes err_count equal MAX_ERR (MAX_ERR != 0).
REQ-024 Wrap-around: expected after all-ones SHALL be zero, which is a match, not an error.
REQ-025 Counters SHALL saturate at 2^CW-1 and never wrap.
REQ-026 start in any state: zero ok_count, err_count, err_flag, last_exp, last_got -> SYNC next cycle; a beat in that cycle is discarded.
REQ-027 stop in SYNC, CHECK or FAIL -> IDLE; counters and flags hold.
REQ-028 If start and stop are both high, stop SHALL win.
REQ-029 All outputs except in_ready SHALL be registered; counter and flag updates are visible one cycle after the beat.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, in_ready 0, locked 0, failed 0, err_flag 0, all counters and last_* zero, expected zero.
REQ-031 Reset release SHALL need no start-up cycles; start is honoured on the first rising edge after release.
REQ-032 Reset mid-stream SHALL drop any in-flight beat; no counter increments.

Structure
REQ-033 Package seq_checker_pkg SHALL hold the state enum (IDLE, SYNC, CHECK, FAIL) and the default-parameter constants.
REQ-034 A sub-module sat_cntr (width CW, clear, inc, asynchronous active-low reset) SHALL be instantiated twice, for ok_count and err_count.

Verification
REQ-035 Reset, start, then stream 4,5,...,15,0,1 with DW=4 -> locked after the first beat, ok_count=13, err_count=0, err_flag=0.
REQ-036 Stream 3,4,7,8 -> err_count=1, last_exp=5, last_got=7, ok_count=2, stays in CHECK.
REQ-037 MAX_ERR=2, stream 1,3,5 -> failed=1 after the beat with word 5, in_ready=0, further beats are not accepted.
REQ-038 start and stop asserted in the same cycle while in CHECK -> IDLE, counters unchanged.
REQ-039 reset_n pulsed low mid-stream -> all outputs zero immediately, IDLE after release.
REQ-040 in_valid toggled randomly on the stream 0..15 -> gaps cause no errors; ok_count equals accepted beats minus 1.
